// File: rtl/systolic_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// systolic_seq_ctrl_pkg
//   Shared definitions for the systolic PE row sequencer: default widths,
//   the controller state encoding and a counter-width helper.
// ---------------------------------------------------------------------------
package systolic_seq_ctrl_pkg;

    localparam int DEF_WORDLENGTH   = 16;
    localparam int DEF_NUM_TAPS     = 8;
    localparam int DEF_IDX_W        = 3;
    localparam int DEF_MULT_TIMEOUT = 31;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACC   = 3'd3,
        ST_EMIT  = 3'd4
    } seq_state_e;

    // Bits needed to hold the values 0..max_count.
    function automatic int cnt_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/systolic_seq_ctrl_wait_timer.sv
// ---------------------------------------------------------------------------
// systolic_seq_ctrl_wait_timer  (the sequencer's wait timer)
//   Loadable up-counter that measures how many cycles the sequencer has spent
//   waiting on the multiplier.
// Ports
//   clk30x   in   system clock
//   reset    in   synchronous, active-high
//   clear_i  in   load the counter with 0
//   en_i     in   count one waiting cycle
//   first_o  out  counter is 0 (first waiting cycle)
//   tc_o     out  this waiting cycle is the MULT_TIMEOUT-th one
// ---------------------------------------------------------------------------
module systolic_seq_ctrl_wait_timer #(
    parameter int MULT_TIMEOUT = 31,
    parameter int CNT_W        = 5
) (
    input  logic clk30x,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic first_o,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, matching real hardware.
    always_ff @(posedge clk30x) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign first_o = (cnt_q == '0);
    // Counter holds (waiting cycles already spent), so the MULT_TIMEOUT-th
    // cycle is the one where it reads MULT_TIMEOUT-1.
    assign tc_o    = (cnt_q == CNT_W'(MULT_TIMEOUT - 1));

endmodule

// File: rtl/systolic_seq_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_seq_ctrl
//   Sequencer for one systolic PE row built on a shared sequential multiplier
//   and adder. Accepts a word, starts the multiplier, waits for its busy flag
//   to drop (with a watchdog), pulses the accumulate load, and after NUM_TAPS
//   words emits the accumulated result.
// Ports
//   clk30x        in   system clock, posedge
//   reset         in   synchronous, active-high
//   in_valid      in   input word offered
//   in_ready      out  controller can accept a word (IDLE only)
//   in_word       in   input word
//   mult_operand  out  registered accepted word, stable until next accept
//   mult_start    out  one-cycle multiplier start pulse
//   mult_busy     in   multiplier busy flag
//   coeff_sel     out  coefficient index (= current word index)
//   acc_clear     out  word index 0: adder's previous-output operand forced to 0
//   acc_load      out  one-cycle pulse: capture adder sum
//   acc_sum       in   adder output
//   out_valid     out  one-cycle pulse: out_word holds a completed result
//   out_word      out  registered result of NUM_TAPS accumulations
//   timeout_err   out  sticky: a multiplication hit the watchdog
// ---------------------------------------------------------------------------
module systolic_seq_ctrl
    import systolic_seq_ctrl_pkg::*;
#(
    parameter int WORDLENGTH   = DEF_WORDLENGTH,
    parameter int NUM_TAPS     = DEF_NUM_TAPS,
    parameter int IDX_W        = DEF_IDX_W,
    parameter int MULT_TIMEOUT = DEF_MULT_TIMEOUT
) (
    input  logic                  clk30x,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORDLENGTH-1:0] in_word,
    output logic [WORDLENGTH-1:0] mult_operand,
    output logic                  mult_start,
    input  logic                  mult_busy,
    output logic [IDX_W-1:0]      coeff_sel,
    output logic                  acc_clear,
    output logic                  acc_load,
    input  logic [WORDLENGTH-1:0] acc_sum,
    output logic                  out_valid,
    output logic [WORDLENGTH-1:0] out_word,
    output logic                  timeout_err
);

    localparam int CNT_W = cnt_width(MULT_TIMEOUT);

    seq_state_e            state_q,    state_d;
    logic [IDX_W-1:0]      idx_q,      idx_d;
    logic [WORDLENGTH-1:0] operand_q,  operand_d;
    logic [WORDLENGTH-1:0] out_word_q, out_word_d;
    logic                  timeout_q,  timeout_d;

    logic timer_clear;
    logic timer_en;
    logic timer_first;
    logic timer_tc;

    systolic_seq_ctrl_wait_timer #(
        .MULT_TIMEOUT (MULT_TIMEOUT),
        .CNT_W        (CNT_W)
    ) u_seq_wait_timer (
        .clk30x  (clk30x),
        .reset   (reset),
        .clear_i (timer_clear),
        .en_i    (timer_en),
        .first_o (timer_first),
        .tc_o    (timer_tc)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        operand_d   = operand_q;
        out_word_d  = out_word_q;
        timeout_d   = timeout_q;
        in_ready    = 1'b0;
        mult_start  = 1'b0;
        acc_load    = 1'b0;
        out_valid   = 1'b0;
        timer_clear = 1'b0;
        timer_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    operand_d = in_word;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                mult_start  = 1'b1;
                timer_clear = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                timer_en = 1'b1;
                // Busy is ignored on the first WAIT cycle: the multiplier
                // raises it one cycle after seeing the start pulse. A genuine
                // completion wins over a watchdog expiry in the same cycle.
                if (!timer_first && !mult_busy) begin
                    state_d = ST_ACC;
                end else if (timer_tc) begin
                    timeout_d = 1'b1;
                    state_d   = ST_ACC;
                end
            end
            ST_ACC: begin
                acc_load = 1'b1;
                // Wrap at NUM_TAPS-1 explicitly, not at 2**IDX_W.
                if (idx_q == IDX_W'(NUM_TAPS - 1)) begin
                    out_word_d = acc_sum;
                    idx_d      = '0;
                    state_d    = ST_EMIT;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk30x) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            operand_q  <= '0;
            out_word_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            operand_q  <= operand_d;
            out_word_q <= out_word_d;
            timeout_q  <= timeout_d;
        end
    end

    assign mult_operand = operand_q;
    assign out_word     = out_word_q;
    assign timeout_err  = timeout_q;
    assign coeff_sel    = idx_q;
    // The index only changes on the edge leaving ACC, so both controls are
    // stable from START through ACC; outside that window acc_clear is held low.
    assign acc_clear    = (idx_q == '0) &&
                          (state_q == ST_START || state_q == ST_WAIT || state_q == ST_ACC);

endmodule
